// File: rtl/datapath_checker_if.sv
// Operand/result snoop bus and status outputs shared between the
// randomized-input harness (master) and the result checker (slave).
interface datapath_checker_if #(parameter int N = 16);
  logic         start;
  logic         stop;
  logic         in_valid;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [2:0]   opcode;
  logic [N-1:0] dut_Y;
  logic         dut_co;
  logic         busy;
  logic         done;
  logic [15:0]  op_count;
  logic [15:0]  err_count;
  logic [15:0]  first_err_idx;
  logic         first_err_valid;

  modport master (
    output start, stop, in_valid, A, B, opcode, dut_Y, dut_co,
    input  busy, done, op_count, err_count, first_err_idx, first_err_valid
  );

  modport slave (
    input  start, stop, in_valid, A, B, opcode, dut_Y, dut_co,
    output busy, done, op_count, err_count, first_err_idx, first_err_valid
  );
endinterface

// File: rtl/datapath_checker.sv
// Golden-model checker for the add/sub datapath: computes {co,Y} at issue
// time, delays it by the datapath latency, compares against the datapath
// outputs and keeps op/mismatch counts plus the index of the first miss.
module datapath_checker #(
  parameter int N   = 16,
  parameter int LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  datapath_checker_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  // last drain cycle index; LAT=0 never enters DRAIN
  localparam logic [2:0] DRAIN_LAST = 3'((LAT > 0) ? LAT - 1 : 0);

  state_t      state_q, state_d;
  logic [2:0]  drain_cnt_q, drain_cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] op_count_q, op_count_d;
  logic [15:0] err_count_q, err_count_d;
  logic [15:0] first_err_idx_q, first_err_idx_d;
  logic        first_err_valid_q, first_err_valid_d;

  logic         issue;
  logic         clr;
  logic [N-1:0] m1, m2;
  logic [N:0]   gold;
  logic         emerge_vld;
  logic [N:0]   emerge_exp;
  logic         check;
  logic         mismatch;

  // an op is only captured while running; start only re-arms from IDLE/DONE
  assign issue = bus.in_valid && (state_q == S_RUN);
  assign clr   = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // golden add/sub result: B gated, optionally inverted, plus carry-in
  always_comb begin
    m1   = bus.opcode[2] ? '0 : bus.B;
    m2   = bus.opcode[1] ? ~m1 : m1;
    gold = {1'b0, bus.A} + {1'b0, m2} + {{N{1'b0}}, bus.opcode[0]};
  end

  if (LAT == 0) begin : g_comb
    // combinational datapath: compare in the issue cycle
    assign emerge_vld = issue;
    assign emerge_exp = gold;
  end else begin : g_pipe
    logic [LAT:1] vld_pipe_q, vld_pipe_d;
    logic [N:0]   exp_pipe_q [LAT:1];
    logic [N:0]   exp_pipe_d [LAT:1];

    // shift expected results down the line; a new run flushes stale entries
    always_comb begin
      vld_pipe_d[1] = issue;
      exp_pipe_d[1] = gold;
      for (int i = 2; i <= LAT; i++) begin
        vld_pipe_d[i] = vld_pipe_q[i-1] && !clr;
        exp_pipe_d[i] = exp_pipe_q[i-1];
      end
    end

    // delay line registers
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_pipe_q <= '0;
        for (int i = 1; i <= LAT; i++) exp_pipe_q[i] <= '0;
      end else begin
        vld_pipe_q <= vld_pipe_d;
        for (int i = 1; i <= LAT; i++) exp_pipe_q[i] <= exp_pipe_d[i];
      end
    end

    assign emerge_vld = vld_pipe_q[LAT];
    assign emerge_exp = exp_pipe_q[LAT];
  end

  assign check    = emerge_vld && ((state_q == S_RUN) || (state_q == S_DRAIN));
  assign mismatch = {bus.dut_co, bus.dut_Y} != emerge_exp;

  // run-control next state; start wins over stop outside RUN
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN: begin
        if (bus.stop) begin
          if (LAT == 0) begin
            state_d = S_DONE;
          end else begin
            state_d     = S_DRAIN;
            drain_cnt_d = 3'd0;
          end
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) state_d = S_DONE;
        else drain_cnt_d = drain_cnt_q + 3'd1;
      end
      S_DONE:  if (bus.start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  // saturating counters and first-mismatch capture
  always_comb begin
    op_count_d        = op_count_q;
    err_count_d       = err_count_q;
    first_err_idx_d   = first_err_idx_q;
    first_err_valid_d = first_err_valid_q;
    if (clr) begin
      op_count_d        = '0;
      err_count_d       = '0;
      first_err_idx_d   = '0;
      first_err_valid_d = 1'b0;
    end else if (check) begin
      if (op_count_q != 16'hFFFF) op_count_d = op_count_q + 16'd1;
      if (mismatch) begin
        if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
        if (!first_err_valid_q) begin
          first_err_idx_d   = op_count_q;
          first_err_valid_d = 1'b1;
        end
      end
    end
  end

  // state and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= S_IDLE;
      drain_cnt_q       <= '0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      op_count_q        <= '0;
      err_count_q       <= '0;
      first_err_idx_q   <= '0;
      first_err_valid_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      drain_cnt_q       <= drain_cnt_d;
      busy_q            <= busy_d;
      done_q            <= done_d;
      op_count_q        <= op_count_d;
      err_count_q       <= err_count_d;
      first_err_idx_q   <= first_err_idx_d;
      first_err_valid_q <= first_err_valid_d;
    end
  end

  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.op_count        = op_count_q;
  assign bus.err_count       = err_count_q;
  assign bus.first_err_idx   = first_err_idx_q;
  assign bus.first_err_valid = first_err_valid_q;

endmodule

// File: tb/tb_datapath_checker.sv
// Bench for datapath_checker: three builds (LAT=1, LAT=0, LAT=3) share one
// stimulus bus, steered by sel. Every status change of a checker is popped
// from that build's queue of expected status snapshots.
module tb_datapath_checker;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic [15:0] opc;
    logic [15:0] errc;
    logic [15:0] fidx;
    logic        fval;
  } snap_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  sel;
  logic        st, sp, iv, dc;
  logic [15:0] a, b, dy;
  logic [2:0]  op;

  int checks = 0;
  int errors = 0;
  bit mon0_en = 1'b1;

  snap_t q0[$], q1[$], q3[$];
  snap_t cur0, cur1, cur3;

  // directed vectors: A, B, opcode -> hand-computed {co, Y}
  logic [15:0] va  [10] = '{16'h0005, 16'h0005, 16'h0005, 16'h0005, 16'h0005,
                            16'h0005, 16'hFFFF, 16'h1234, 16'h00FF, 16'h8000};
  logic [15:0] vb  [10] = '{16'h0003, 16'h0003, 16'h0003, 16'h0003, 16'h0003,
                            16'h0003, 16'h0001, 16'h1234, 16'h000F, 16'h8000};
  logic [2:0]  vop [10] = '{3'd0, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd3, 3'd2, 3'd1};
  logic        vco [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [15:0] vy  [10] = '{16'h0008, 16'h0002, 16'h0005, 16'h0006, 16'h0004,
                            16'h0005, 16'h0000, 16'h0000, 16'h00EF, 16'h0001};

  // per-op fault injection for the current run
  logic        fy_en  [16];
  logic [15:0] fy_val [16];
  logic        fco    [16];

  always #5 clk = ~clk;

  datapath_checker_if #(.N(16)) if0();
  datapath_checker_if #(.N(16)) if1();
  datapath_checker_if #(.N(16)) if3();

  datapath_checker #(.N(16), .LAT(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  datapath_checker #(.N(16), .LAT(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  datapath_checker #(.N(16), .LAT(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  assign if0.start    = (sel == 2'd0) && st;
  assign if0.stop     = (sel == 2'd0) && sp;
  assign if0.in_valid = (sel == 2'd0) && iv;
  assign if0.A        = (sel == 2'd0) ? a  : '0;
  assign if0.B        = (sel == 2'd0) ? b  : '0;
  assign if0.opcode   = (sel == 2'd0) ? op : '0;
  assign if0.dut_Y    = (sel == 2'd0) ? dy : '0;
  assign if0.dut_co   = (sel == 2'd0) && dc;

  assign if1.start    = (sel == 2'd1) && st;
  assign if1.stop     = (sel == 2'd1) && sp;
  assign if1.in_valid = (sel == 2'd1) && iv;
  assign if1.A        = (sel == 2'd1) ? a  : '0;
  assign if1.B        = (sel == 2'd1) ? b  : '0;
  assign if1.opcode   = (sel == 2'd1) ? op : '0;
  assign if1.dut_Y    = (sel == 2'd1) ? dy : '0;
  assign if1.dut_co   = (sel == 2'd1) && dc;

  assign if3.start    = (sel == 2'd3) && st;
  assign if3.stop     = (sel == 2'd3) && sp;
  assign if3.in_valid = (sel == 2'd3) && iv;
  assign if3.A        = (sel == 2'd3) ? a  : '0;
  assign if3.B        = (sel == 2'd3) ? b  : '0;
  assign if3.opcode   = (sel == 2'd3) ? op : '0;
  assign if3.dut_Y    = (sel == 2'd3) ? dy : '0;
  assign if3.dut_co   = (sel == 2'd3) && dc;

  assign cur0 = {if0.busy, if0.done, if0.op_count, if0.err_count, if0.first_err_idx, if0.first_err_valid};
  assign cur1 = {if1.busy, if1.done, if1.op_count, if1.err_count, if1.first_err_idx, if1.first_err_valid};
  assign cur3 = {if3.busy, if3.done, if3.op_count, if3.err_count, if3.first_err_idx, if3.first_err_valid};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic mon_cmp(input int id, input snap_t act, input bit have, input snap_t exp);
    checks++;
    if (!have) begin
      errors++;
      $display("FAIL mon%0d unexpected status change: got %h, expected no change", id, act);
    end else if (act !== exp) begin
      errors++;
      $display("FAIL mon%0d status: got busy=%b done=%b op=%h err=%h fidx=%h fval=%b, expected busy=%b done=%b op=%h err=%h fidx=%h fval=%b",
               id, act.busy, act.done, act.opc, act.errc, act.fidx, act.fval,
               exp.busy, exp.done, exp.opc, exp.errc, exp.fidx, exp.fval);
    end
  endtask

  task automatic push(input int which, input snap_t s);
    case (which)
      0:       q0.push_back(s);
      1:       q1.push_back(s);
      default: q3.push_back(s);
    endcase
  endtask

  task automatic clear_faults();
    for (int i = 0; i < 16; i++) begin
      fy_en[i] = 1'b0; fy_val[i] = '0; fco[i] = 1'b0;
    end
  endtask

  // One framed run: start, n back-to-back ops from the table (stop with the
  // last), datapath results presented lat cycles later. ss puts stop with
  // start; smid pulses start at that op cycle.
  task automatic run(input int which, input int lat, input int base, input int n,
                     input bit ss, input int smid);
    int    k;
    int    errc;
    int    fidx;
    bit    fval;
    bit    bad;
    snap_t s;
    errc = 0; fidx = 0; fval = 1'b0;
    sel = 2'(which);
    st = 1'b1; sp = ss; iv = 1'b0; a = '0; b = '0; op = '0;
    dy = 16'($urandom); dc = 1'($urandom);
    s = {1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0};
    push(which, s);
    tick();
    for (int cyc = 0; cyc < n + lat; cyc++) begin
      k  = cyc - lat;
      st = (cyc == smid);
      iv = (cyc < n);
      sp = (cyc == n - 1);
      if (cyc < n) begin
        a = va[base+cyc]; b = vb[base+cyc]; op = vop[base+cyc];
      end else begin
        a = 16'($urandom); b = 16'($urandom); op = 3'($urandom);
      end
      if (k >= 0) begin
        dy  = fy_en[k] ? fy_val[k] : vy[base+k];
        dc  = vco[base+k] ^ fco[k];
        bad = (fy_en[k] && (fy_val[k] != vy[base+k])) || fco[k];
        if (bad) begin
          errc++;
          if (!fval) begin fidx = k; fval = 1'b1; end
        end
        s = {(k != n - 1), (k == n - 1), 16'(k + 1), 16'(errc), 16'(fidx), fval};
        push(which, s);
      end else begin
        dy = 16'($urandom); dc = 1'($urandom);
      end
      tick();
    end
    st = 1'b0; sp = 1'b0; iv = 1'b0;
  endtask

  // scoreboard monitor: every status change must match the next snapshot
  initial begin : monitor
    snap_t p0, p1, p3, e;
    p0 = '0; p1 = '0; p3 = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        p0 = cur0; p1 = cur1; p3 = cur3;
      end else begin
        if (cur0 !== p0) begin
          if (mon0_en) begin
            if (q0.size() == 0) mon_cmp(0, cur0, 1'b0, '0);
            else begin e = q0.pop_front(); mon_cmp(0, cur0, 1'b1, e); end
          end
          p0 = cur0;
        end
        if (cur1 !== p1) begin
          if (q1.size() == 0) mon_cmp(1, cur1, 1'b0, '0);
          else begin e = q1.pop_front(); mon_cmp(1, cur1, 1'b1, e); end
          p1 = cur1;
        end
        if (cur3 !== p3) begin
          if (q3.size() == 0) mon_cmp(3, cur3, 1'b0, '0);
          else begin e = q3.pop_front(); mon_cmp(3, cur3, 1'b1, e); end
          p3 = cur3;
        end
      end
    end
  end

  initial begin : stim
    rst_n = 1'b0; sel = 2'd2;
    st = 1'b0; sp = 1'b0; iv = 1'b0; dc = 1'b0;
    a = '0; b = '0; op = '0; dy = '0;
    clear_faults();
    tick(); tick();
    chk("reset busy1",    32'(if1.busy), 32'd0);
    chk("reset done1",    32'(if1.done), 32'd0);
    chk("reset opc1",     32'(if1.op_count), 32'd0);
    chk("reset fval1",    32'(if1.first_err_valid), 32'd0);
    chk("reset status0",  32'(cur0), 32'd0);
    chk("reset status3",  32'(cur3), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: six opcodes, correct datapath, LAT=1
    run(1, 1, 0, 6, 1'b0, -1);
    chk("t1 op_count", 32'(if1.op_count), 32'd6);
    chk("t1 err_count", 32'(if1.err_count), 32'd0);
    chk("t1 fval", 32'(if1.first_err_valid), 32'd0);
    chk("t1 done", 32'(if1.done), 32'd1);

    // 2: forced Y on 3rd and 5th op
    clear_faults();
    fy_en[2] = 1'b1; fy_val[2] = 16'h0009;
    fy_en[4] = 1'b1; fy_val[4] = 16'h0009;
    run(1, 1, 0, 6, 1'b0, -1);
    chk("t2 err_count", 32'(if1.err_count), 32'd2);
    chk("t2 first_err_idx", 32'(if1.first_err_idx), 32'd2);
    chk("t2 fval", 32'(if1.first_err_valid), 32'd1);

    // 3: carry-only fault on 0xFFFF + 1
    clear_faults();
    fco[0] = 1'b1;
    run(1, 1, 6, 1, 1'b0, -1);
    chk("t3 err_count", 32'(if1.err_count), 32'd1);
    chk("t3 first_err_idx", 32'(if1.first_err_idx), 32'd0);
    chk("t3 op_count", 32'(if1.op_count), 32'd1);

    // 4: LAT=0, ten back-to-back ops, stop with the tenth
    clear_faults();
    run(0, 0, 0, 10, 1'b0, -1);
    chk("t4 op_count", 32'(if0.op_count), 32'd10);
    chk("t4 err_count", 32'(if0.err_count), 32'd0);
    chk("t4 done", 32'(if0.done), 32'd1);

    // 5: LAT=3, async reset in DRAIN with two ops still in flight
    sel = 2'd3;
    push(3, {1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0});
    st = 1'b1; tick(); st = 1'b0;
    iv = 1'b1; a = va[0]; b = vb[0]; op = vop[0]; tick();
    sp = 1'b1; a = va[1]; b = vb[1]; op = vop[1]; tick();
    sp = 1'b0; iv = 1'b0;
    chk("t5 busy before reset", 32'(if3.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5 status3 after reset", 32'(cur3), 32'd0);
    chk("t5 status1 after reset", 32'(cur1), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run(3, 3, 7, 3, 1'b0, -1);
    chk("t5 rerun op_count", 32'(if3.op_count), 32'd3);
    chk("t5 rerun err_count", 32'(if3.err_count), 32'd0);

    // 6: in_valid in IDLE, start in RUN, start+stop in DONE
    sel = 2'd1;
    for (int i = 0; i < 3; i++) begin
      iv = 1'b1; a = 16'($urandom); b = 16'($urandom); op = 3'($urandom);
      dy = 16'($urandom); tick();
    end
    iv = 1'b0;
    chk("t6 idle op_count", 32'(if1.op_count), 32'd0);
    chk("t6 idle busy", 32'(if1.busy), 32'd0);
    run(1, 1, 0, 6, 1'b0, 3);
    chk("t6 start-in-run op_count", 32'(if1.op_count), 32'd6);
    fy_en[0] = 1'b1; fy_val[0] = 16'h1111;
    run(1, 1, 0, 6, 1'b0, -1);
    clear_faults();
    run(1, 1, 0, 6, 1'b1, -1);
    chk("t6 start+stop op_count", 32'(if1.op_count), 32'd6);
    chk("t6 start+stop err_count", 32'(if1.err_count), 32'd0);
    chk("t6 start+stop fval", 32'(if1.first_err_valid), 32'd0);

    // 6: 65537 mismatching ops on LAT=0 -> both counters saturate
    mon0_en = 1'b0;
    sel = 2'd0;
    st = 1'b1; tick(); st = 1'b0;
    a = '0; b = '0; op = '0; dy = 16'h0001; dc = 1'b0;
    for (int i = 0; i < 65537; i++) begin
      iv = 1'b1; sp = (i == 65536); tick();
    end
    iv = 1'b0; sp = 1'b0;
    chk("t6 sat op_count", 32'(if0.op_count), 32'h0000FFFF);
    chk("t6 sat err_count", 32'(if0.err_count), 32'h0000FFFF);
    chk("t6 sat first_err_idx", 32'(if0.first_err_idx), 32'd0);
    chk("t6 sat done", 32'(if0.done), 32'd1);

    tick(); tick();
    chk("q0 drained", 32'(q0.size()), 32'd0);
    chk("q1 drained", 32'(q1.size()), 32'd0);
    chk("q3 drained", 32'(q3.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/datapath_checker.md
Name: datapath_checker

Overview:
- Result-side companion to the add/sub arithmetic datapath: snoops each operand set issued to the datapath (A, B, opcode) and computes the golden {co, Y}.
- Delays the golden result by the datapath pipeline latency and compares it against the datapath outputs.
- Counts issued operations and mismatches, and captures the index of the first mismatch.
- Sits beside the datapath in the randomized-input test harness; a run-control FSM frames each test run.

Parameters:
- N, 16, operand/result width (even, >=2)
- LAT, 1, datapath latency in cycles (0..7); 0 = combinational datapath, 1 = registered-input datapath

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin run (pulse)
- stop  input  1  end issue phase (pulse)
- in_valid  input  1  operand set presented to datapath this cycle
- A  input  N  operand A as driven to datapath
- B  input  N  operand B as driven to datapath
- opcode  input  3  opcode as driven to datapath
- dut_Y  input  N  datapath result
- dut_co  input  1  datapath carry-out
- busy  output  1  high in RUN or DRAIN
- done  output  1  high in DONE
- op_count  output  16  operations checked
- err_count  output  16  mismatches
- first_err_idx  output  16  op_count value at first mismatch
- first_err_valid  output  1  a mismatch has been recorded

Behaviour:
- Reset, async on rst_n low: FSM=IDLE; all outputs 0; delay line cleared; drain counter 0. Reset mid-run aborts the run; nothing is retained.
- Golden model, computed at issue time:
  - m1 = opcode[2] ? 0 : B
  - m2 = opcode[1] ? ~m1 : m1
  - {exp_co, exp_Y} = A + m2 + opcode[0], evaluated as an unsigned (N+1)-bit sum; exp_co is the unsigned carry-out.
- Delay line:
  - LAT stages; each stage holds {valid, exp_co, exp_Y}.
  - Stage 0 loads in_valid && (state==RUN).
  - The entry emerging at stage LAT is checked against dut_Y/dut_co sampled on the same rising edge.
  - LAT=0: the check is same-cycle against the combinational golden value.
- Check, for an op issued in cycle t:
  - Compare at the edge ending cycle t+LAT.
  - op_count += 1.
  - On mismatch of Y or co: err_count += 1. If first_err_valid==0, first_err_idx <= pre-increment op_count and first_err_valid <= 1.
  - Both counters saturate at 0xFFFF.
  - Updates are visible in cycle t+LAT+1.
- FSM:
  - IDLE: start -> RUN. Clear counters, first_err_*, and delay line.
  - RUN: accept in_valid every cycle (no backpressure). stop -> DRAIN; an in_valid in the stop cycle is accepted. If LAT=0, stop -> DONE directly.
  - DRAIN: stage 0 loads invalid; checks continue; counter runs LAT cycles, then -> DONE. Every op issued before the stop edge is checked before DONE.
  - DONE: outputs frozen. start -> RUN with the same clearing as from IDLE.
- Simultaneous start and stop:
  - In IDLE/DONE: start wins.
  - In RUN: stop acted on, start ignored.
  - start in RUN/DRAIN: ignored.
- in_valid outside RUN: ignored. dut_Y/dut_co are ignored unless the emerging stage is valid.
- busy = RUN|DRAIN; done = (state==DONE). Both are registered state decodes.

Test Plan:
1. N=16, LAT=1, correct DUT model. Issue A=0x0005, B=0x0003 with opcodes 000, 011, 100, 101, 110, 111; expected {co,Y} respectively 0/0x0008, 1/0x0002, 0/0x0005, 0/0x0006, 1/0x0004, 1/0x0005. Then stop -> DONE one cycle after DRAIN entry; op_count=6, err_count=0, first_err_valid=0.
2. Fault injection, LAT=1: force dut_Y=0x0009 for the 3rd op only -> err_count=1, first_err_idx=2, first_err_valid=1. A further forced error on the 5th op -> err_count=2, first_err_idx stays 2.
3. Carry-only fault: A=0xFFFF, B=0x0001, op=000, force dut_co=0 -> expected Y=0x0000, co=1; mismatch counted.
4. LAT=0 build: back-to-back 10 ops with in_valid held high, stop with 10th -> DONE next cycle, op_count=10. Also: stop and in_valid in the same cycle -> that op is counted.
5. Reset mid-DRAIN: LAT=3 with 2 ops pending; assert rst_n low asynchronously between edges -> outputs 0 immediately and IDLE. A subsequent start run counts from 0.
6. Control corners: start while RUN has no effect; start+stop together in DONE -> RUN with counters cleared; in_valid in IDLE not counted. Drive 65537 ops -> op_count saturates at 0xFFFF.
